// File: rtl/serial_tx_controller_pkg.sv
// Shared types and default constants for the serial transmit controller.
// The PARITY state exists only when RSD_SERIAL_TX_PARITY_EN is defined.
package SerialTxTypes;

  localparam int SERIAL_TX_FIFO_DEPTH = 16;
  localparam int SERIAL_TX_CLK_DIV    = 542;

  typedef logic [7:0] SerialDataPath;

  typedef enum logic [2:0] {
    SERIAL_TX_IDLE   = 3'd0,
    SERIAL_TX_START  = 3'd1,
    SERIAL_TX_DATA   = 3'd2,
`ifdef RSD_SERIAL_TX_PARITY_EN
    SERIAL_TX_PARITY = 3'd3,
`endif
    SERIAL_TX_STOP   = 3'd4
  } SerialTxState;

  function automatic logic even_parity(input SerialDataPath data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_tx_controller_fifo.sv
// Single-clock first-word-fall-through byte FIFO feeding the UART shifter.
// A push while full is still accepted when a pop happens on the same edge.
module serial_tx_fifo
  import SerialTxTypes::*;
#(
  parameter int DEPTH = SERIAL_TX_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       negResetIn,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  SerialDataPath              i_data,
  output SerialDataPath              o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  SerialDataPath    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally; occupancy holds on a simultaneous push and pop.
  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_controller.sv
// UART transmitter: buffers IO-unit byte writes and serializes them as 8N1,
// or 8E1 when RSD_SERIAL_TX_PARITY_EN is defined.
module serial_tx_controller
  import SerialTxTypes::*;
#(
  parameter int FIFO_DEPTH = SERIAL_TX_FIFO_DEPTH,
  parameter int CLK_DIV    = SERIAL_TX_CLK_DIV
) (
  input  logic          clk,
  input  logic          negResetIn,
  input  logic          serialWE,
  input  SerialDataPath serialWriteData,
  output logic          serialFull,
  output logic          txBusy,
  output logic [15:0]   dropCount,
  output logic          txd
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  SerialTxState      r_state;
  SerialTxState      w_state_next;
  SerialDataPath     r_shift;
  SerialDataPath     w_shift_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_next;
  logic              r_txd;
  logic              w_txd_next;
  logic [15:0]       r_drop_cnt;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_reject;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  SerialDataPath     w_fifo_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_parity_bit;

  serial_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .negResetIn (negResetIn),
    .i_push     (serialWE),
    .i_pop      (w_pop),
    .i_data     (serialWriteData),
    .o_head     (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );

  assign w_bit_end = (r_baud == BAUD_W'(CLK_DIV - 1));
  assign w_reject  = serialWE && w_fifo_full && !w_pop;

`ifdef RSD_SERIAL_TX_PARITY_EN
  logic r_parity;

  // Parity is captured at load time because the shifter loses the data bits.
  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= even_parity(w_fifo_head);
    end else begin
      r_parity <= r_parity;
    end
  end

  assign w_parity_bit = r_parity;
`else
  assign w_parity_bit = 1'b1;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_baud_next    = w_bit_end ? '0 : r_baud + BAUD_W'(1);
    w_pop          = 1'b0;
    case (r_state)
      SERIAL_TX_IDLE: begin
        w_baud_next = '0;
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_fifo_head;
          w_bit_idx_next = 3'd0;
          w_state_next   = SERIAL_TX_START;
        end else begin
          w_state_next = SERIAL_TX_IDLE;
        end
      end
      SERIAL_TX_START: begin
        if (w_bit_end) w_state_next = SERIAL_TX_DATA;
        else           w_state_next = SERIAL_TX_START;
      end
      SERIAL_TX_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef RSD_SERIAL_TX_PARITY_EN
          w_state_next = SERIAL_TX_PARITY;
`else
          w_state_next = SERIAL_TX_STOP;
`endif
        end else if (w_bit_end) begin
          w_shift_next   = {1'b0, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
        end else begin
          w_state_next = SERIAL_TX_DATA;
        end
      end
`ifdef RSD_SERIAL_TX_PARITY_EN
      SERIAL_TX_PARITY: begin
        if (w_bit_end) w_state_next = SERIAL_TX_STOP;
        else           w_state_next = SERIAL_TX_PARITY;
      end
`endif
      SERIAL_TX_STOP: begin
        // Back-to-back frames: reload straight into START with no idle bit.
        if (w_bit_end && !w_fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_fifo_head;
          w_bit_idx_next = 3'd0;
          w_state_next   = SERIAL_TX_START;
        end else if (w_bit_end) begin
          w_state_next = SERIAL_TX_IDLE;
        end else begin
          w_state_next = SERIAL_TX_STOP;
        end
      end
      default: begin
        w_state_next = SERIAL_TX_IDLE;
      end
    endcase

    case (w_state_next)
      SERIAL_TX_START:  w_txd_next = 1'b0;
      SERIAL_TX_DATA:   w_txd_next = w_shift_next[0];
`ifdef RSD_SERIAL_TX_PARITY_EN
      SERIAL_TX_PARITY: w_txd_next = w_parity_bit;
`endif
      default:          w_txd_next = 1'b1;
    endcase
  end

  // FSM, shifter and line register; txd is driven high as soon as reset asserts.
  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      r_state   <= SERIAL_TX_IDLE;
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_baud    <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_baud    <= w_baud_next;
      r_txd     <= w_txd_next;
    end
  end

  // Saturating count of writes rejected while the FIFO is full.
  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      r_drop_cnt <= 16'h0000;
    end else if (w_reject && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign serialFull = w_fifo_full;
  assign txBusy     = (r_state != SERIAL_TX_IDLE) || (w_fifo_count != '0);
  assign txd        = r_txd;
  assign dropCount  = r_drop_cnt;

  logic w_unused;
  assign w_unused = w_parity_bit;

endmodule

// File: tb/tb_serial_tx_controller.sv
// Directed and random stimulus checked every cycle against a frame-level
// model of the UART line (queue of pending bytes plus position in frame).
module tb_serial_tx_controller;

  localparam int DEPTH = 4;
  localparam int DIV   = 4;
`ifdef RSD_SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN = FRAME_BITS * DIV;

  logic        clk = 1'b0;
  logic        negResetIn = 1'b0;
  logic        serialWE = 1'b0;
  logic [7:0]  serialWriteData = 8'h00;
  logic        serialFull;
  logic        txBusy;
  logic [15:0] dropCount;
  logic        txd;

  serial_tx_controller #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
    .clk             (clk),
    .negResetIn      (negResetIn),
    .serialWE        (serialWE),
    .serialWriteData (serialWriteData),
    .serialFull      (serialFull),
    .txBusy          (txBusy),
    .dropCount       (dropCount),
    .txd             (txd)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [7:0]  m_q[$];
  logic [7:0]  m_byte = 8'h00;
  int          m_cyc = -1;
  logic [15:0] m_drop = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (m_cyc < 0) return 1'b1;
    k = m_cyc / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
`ifdef RSD_SERIAL_TX_PARITY_EN
    if (k == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cyc = -1;
    m_drop = 16'h0000;
  endtask

  task automatic model_step(input logic we, input logic [7:0] d);
    bit line_busy;
    bit pop;
    bit accept;
    line_busy = (m_cyc >= 0);
    pop = (m_q.size() > 0) && (!line_busy || (m_cyc == FRAME_LEN - 1));
    accept = we && ((m_q.size() < DEPTH) || pop);
    if (line_busy) m_cyc++;
    if (m_cyc == FRAME_LEN) m_cyc = -1;
    if (pop) begin
      m_byte = m_q.pop_front();
      m_cyc = 0;
    end
    if (accept) m_q.push_back(d);
    else if (we && (m_drop != 16'hFFFF)) m_drop++;
  endtask

  task automatic check_outputs();
    chk("txd", {15'd0, txd}, {15'd0, exp_txd()});
    chk("serialFull", {15'd0, serialFull}, {15'd0, m_q.size() == DEPTH});
    chk("txBusy", {15'd0, txBusy}, {15'd0, (m_cyc >= 0) || (m_q.size() != 0)});
    chk("dropCount", dropCount, m_drop);
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    serialWE = we;
    serialWriteData = d;
    @(posedge clk);
    model_step(we, d);
    #1;
    check_outputs();
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 2000 && !(m_cyc < 0 && m_q.size() == 0); i++) step(1'b0, 8'h00);
    chk("drain_bound", {15'd0, i < 2000}, 16'd1);
  endtask

  initial begin
    int n;
    int rate;
    negResetIn = 1'b0;
    repeat (3) @(posedge clk);
    #2 negResetIn = 1'b1;
    check_outputs();

    // single byte 0x55
    step(1'b1, 8'h55);
    chk("single_busy_after_write", {15'd0, txBusy}, 16'd1);
    chk("single_txd_before_start", {15'd0, txd}, 16'd1);
    step(1'b0, 8'h00);
    chk("single_txd_fall", {15'd0, txd}, 16'd0);
    n = 0;
    while (txBusy && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("single_frame_len", n[15:0], FRAME_LEN[15:0]);
    drain();

    // back-to-back frames
    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    step(1'b1, 8'h43);
    drain();

    // overflow with 10 consecutive writes
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, i[7:0]);
      if (i == 4) chk("ovf_not_full_4", {15'd0, serialFull}, 16'd0);
      if (i == 5) chk("ovf_full_5", {15'd0, serialFull}, 16'd1);
    end
    chk("ovf_drop", dropCount, 16'd5);
    drain();

    // full FIFO: drop in a non-pop cycle, accept on the STOP pop cycle
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + i[7:0]);
    chk("fullpop_full", {15'd0, serialFull}, 16'd1);
    step(1'b1, 8'hEE);
    chk("fullpop_drop_nonpop", dropCount, 16'd6);
    n = 0;
    while (m_cyc != FRAME_LEN - 1 && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    step(1'b1, 8'hA5);
    chk("fullpop_drop_unchanged", dropCount, 16'd6);
    chk("fullpop_still_full", {15'd0, serialFull}, 16'd1);
    drain();

    // parity-relevant byte
    step(1'b1, 8'h07);
    drain();

    // reset during data bit 3
    step(1'b1, 8'hC3);
    n = 0;
    while ((m_cyc < 0 || m_cyc / DIV != 4) && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("rst_pre_txd", {15'd0, txd}, {15'd0, exp_txd()});
    #2 negResetIn = 1'b0;
    #1;
    model_reset();
    chk("rst_txd_async", {15'd0, txd}, 16'd1);
    check_outputs();
    #3 negResetIn = 1'b1;
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00);

    // random traffic with varying write density
    for (int seg = 0; seg < 8; seg++) begin
      rate = $urandom_range(1, 60);
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 99) < rate, 8'($urandom));
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
